// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack boot loader.
package hack_pkg;

    localparam int HACK_ROM_DEPTH = 32768;
    localparam int HACK_WORD_W    = 16;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_FAIL
    } boot_state_t;

    function automatic logic is_loading(input boot_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/hack_boot_timer.sv
// Loadable down-counter. zero_o flags an empty count; tc_o marks the cycle
// in which an enabled count steps from 1 to 0.
module hack_boot_timer #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign tc_o   = en_i && !load_i && (cnt_q == W'(1));

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot/run controller: holds the Hack CPU in reset, loads ROM words from a
// byte stream, then releases the CPU.
//   HOLD cpu held, hold timer running | RUN cpu running | LEN_HI/LEN_LO word count
//   DATA_HI/DATA_LO word bytes, write on low byte | FAIL bad count or timeout
module hack_boot_ctrl
    import hack_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int ROM_DEPTH  = HACK_ROM_DEPTH,
    parameter int RESET_HOLD = 16,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   cpu_reset,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [HACK_WORD_W-1:0] rom_wdata,
    output logic                   busy,
    output logic                   error
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    boot_state_t             state_q, state_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [7:0]              data_hi_q, data_hi_d;
    logic [15:0]             remain_q, remain_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    logic [HACK_WORD_W-1:0]  rom_wdata_q, rom_wdata_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;

    logic hold_load, hold_zero, hold_tc, hold_done;
    logic to_load, to_zero, to_tc, to_done, loading;

    assign loading   = is_loading(state_q);
    assign hold_done = hold_tc || hold_zero;
    assign to_done   = to_tc || to_zero;

    hack_boot_timer #(.W(HOLD_W), .RST_VAL(HOLD_W'(RESET_HOLD))) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (hold_load),
        .load_val_i (HOLD_W'(RESET_HOLD)),
        .en_i       (state_q == ST_HOLD),
        .zero_o     (hold_zero),
        .tc_o       (hold_tc)
    );

    hack_boot_timer #(.W(TO_W), .RST_VAL(TO_W'(TIMEOUT))) u_idle_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (to_load),
        .load_val_i (TO_W'(TIMEOUT)),
        .en_i       (loading),
        .zero_o     (to_zero),
        .tc_o       (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        data_hi_d   = data_hi_q;
        remain_d    = remain_q;
        addr_d      = addr_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        to_load     = 1'b0;

        // start outranks a same-cycle byte, which is simply dropped
        if (start) begin
            state_d = ST_LEN_HI;
            addr_d  = '0;
            to_load = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: if (hold_done) state_d = ST_RUN;
                ST_RUN:  ;
                ST_LEN_HI: if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: if (rx_valid) begin
                    remain_d = {len_hi_q, rx_data};
                    if (remain_d == 16'd0) begin
                        state_d = ST_HOLD;
                    end else if ({16'd0, remain_d} > 32'(ROM_DEPTH)) begin
                        state_d = ST_FAIL;
                    end else begin
                        addr_d  = '0;
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: if (rx_valid) begin
                    data_hi_d = rx_data;
                    state_d   = ST_DATA_LO;
                end
                ST_DATA_LO: if (rx_valid) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = addr_q;
                    rom_wdata_d = {data_hi_q, rx_data};
                    remain_d    = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_DATA_HI;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_HOLD;
            endcase

            if (loading) begin
                if (rx_valid) begin
                    to_load = 1'b1;
                end else if (to_done) begin
                    state_d = ST_FAIL;
                end
            end
        end

        hold_load   = (state_d == ST_HOLD) && (state_q != ST_HOLD);
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = is_loading(state_d);
        error_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            len_hi_q    <= '0;
            data_hi_q   <= '0;
            remain_q    <= '0;
            addr_q      <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            data_hi_q   <= data_hi_d;
            remain_q    <= remain_d;
            addr_q      <= addr_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl; ROM writes are checked through a
// scoreboard queue drained by a negedge monitor.
module tb_hack_boot_ctrl;

    localparam int ADDR_W     = 15;
    localparam int RESET_HOLD = 16;
    localparam int TIMEOUT    = 200;

    logic              clk;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              cpu_reset;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              busy;
    logic              error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    logic [30:0] exp_q[$];

    hack_boot_ctrl #(
        .ADDR_W     (ADDR_W),
        .RESET_HOLD (RESET_HOLD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cpu_reset (cpu_reset),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .busy      (busy),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rom_we) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("unexpected_rom_we", {1'b0, rom_addr, rom_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("rom_write", {1'b0, rom_addr, rom_wdata}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Count edges until cpu_reset drops, bounded so a stuck DUT still ends.
    task automatic wait_cpu_release(input string name);
        int cycles = 0;
        while (cpu_reset && cycles < 100) begin
            tick();
            cycles++;
        end
        check(name, cycles, RESET_HOLD);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_rom_we", rom_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_wdata", rom_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);

        // power-on hold
        tick();
        reset = 1'b0;
        wait_cpu_release("poweron_hold_cycles");
        repeat (10) tick();
        check("poweron_stays_run", cpu_reset, 0);
        check("poweron_no_we", n_we, 0);

        // three-word load
        pulse_start();
        check("load3_cpu_reset_rise", cpu_reset, 1);
        check("load3_busy_start", busy, 1);
        expect_write(0, 16'h1234);
        expect_write(1, 16'hABCD);
        expect_write(2, 16'h0007);
        begin
            logic [7:0] s[8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
            for (int i = 0; i < 8; i++) begin
                send_byte(s[i]);
                if (i < 7) check("load3_busy", busy, 1);
            end
        end
        check("load3_we_pulse", rom_we, 1);
        wait_cpu_release("load3_hold_cycles");
        check("load3_queue_empty", exp_q.size(), 0);
        check("load3_error", error, 0);

        // zero-length load
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_busy", busy, 0);
        check("n0_cpu_reset", cpu_reset, 1);
        wait_cpu_release("n0_hold_cycles");
        check("n0_error", error, 0);

        // count too large
        pulse_start();
        send_byte(8'h80);
        send_byte(8'h01);
        check("big_error", error, 1);
        check("big_busy", busy, 0);
        repeat (30) tick();
        check("big_cpu_reset_held", cpu_reset, 1);
        check("big_error_sticky", error, 1);
        pulse_start();
        check("big_error_cleared", error, 0);
        check("big_restart_busy", busy, 1);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_cpu_release("big_recover_hold");

        // idle timeout
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (TIMEOUT - 1) tick();
        check("to_not_yet", error, 0);
        tick();
        check("to_error", error, 1);
        check("to_busy", busy, 0);
        check("to_cpu_reset", cpu_reset, 1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_cpu_release("to_recover_hold");

        // restart mid-load with a colliding byte
        pulse_start();
        expect_write(0, 16'h1111);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h11);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        check("restart_busy", busy, 1);
        expect_write(0, 16'h55AA);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_cpu_release("restart_hold");
        check("restart_queue_empty", exp_q.size(), 0);

        // asynchronous reset mid-load
        pulse_start();
        expect_write(0, 16'h1234);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cpu_reset", cpu_reset, 1);
        check("arst_busy", busy, 0);
        check("arst_rom_we", rom_we, 0);
        check("arst_rom_addr", rom_addr, 0);
        tick();
        reset = 1'b0;
        wait_cpu_release("arst_hold");

        check("total_we", n_we, 6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
